// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the Minisys execute stage: 32-step shift-add multiplier and
// restoring divider, plus mthi/mtlo writes and the mfhi/mflo read mux.
module hilo_muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        HI_LO_write,
    input  logic [5:0]  Function_opcode,
    input  logic [1:0]  HI_LO_move,
    input  logic [1:0]  Mt_HI_LO,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Read_data_2,
    output logic        Stall_HI_LO,
    output logic [31:0] HI_LO_data,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [63:0]   w_q, w_d;        // mult: {acc, multiplier}; div: {rem, quotient}
    logic [31:0]   b_q, b_d;        // multiplicand or divisor magnitude
    logic [31:0]   rs_q, rs_d;      // raw dividend, returned on divide by zero
    logic          is_div_q, is_div_d;
    logic          neg_q, neg_d;    // product / quotient sign
    logic          rneg_q, rneg_d;  // remainder sign (dividend sign)
    logic          div0_q, div0_d;

    logic        start;
    logic        signed_op, div_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_next, iter_next, mul_res;
    logic [31:0] q_res, r_res;

    // The four mult/div funct codes all share 0110xx.
    assign start     = HI_LO_write && (Function_opcode[5:2] == 4'b0110);
    assign signed_op = ~Function_opcode[0];
    assign div_op    = Function_opcode[1];
    assign a_neg     = signed_op & Read_data_1[31];
    assign b_neg     = signed_op & Read_data_2[31];
    assign a_mag     = a_neg ? (32'd0 - Read_data_1) : Read_data_1;
    assign b_mag     = b_neg ? (32'd0 - Read_data_2) : Read_data_2;

    assign mul_sum  = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next = {mul_sum, w_q[31:1]};

    // A shifted remainder that needs 33 bits always exceeds the divisor, so
    // the 32-bit difference is exact whenever it is taken.
    assign div_shift = {w_q[63:32], w_q[31]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_sub   = div_shift[31:0] - b_q;
    assign div_next  = div_ge ? {div_sub, w_q[30:0], 1'b1}
                              : {div_shift[31:0], w_q[30:0], 1'b0};

    assign iter_next = is_div_q ? div_next : mul_next;
    assign mul_res   = neg_q  ? (64'd0 - iter_next) : iter_next;
    assign q_res     = neg_q  ? (32'd0 - iter_next[31:0])  : iter_next[31:0];
    assign r_res     = rneg_q ? (32'd0 - iter_next[63:32]) : iter_next[63:32];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        w_d         = w_q;
        b_d         = b_q;
        rs_d        = rs_q;
        is_div_d    = is_div_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        div0_d      = div0_q;
        Stall_HI_LO = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    Stall_HI_LO = 1'b1;
                    state_d     = S_BUSY;
                    cnt_d       = '0;
                    is_div_d    = div_op;
                    neg_d       = a_neg ^ b_neg;
                    rneg_d      = a_neg;
                    div0_d      = div_op && (Read_data_2 == 32'd0);
                    rs_d        = Read_data_1;
                    w_d         = div_op ? {32'd0, a_mag} : {32'd0, b_mag};
                    b_d         = div_op ? b_mag : a_mag;
                end else begin
                    if (Mt_HI_LO[1]) hi_d = Read_data_1;
                    if (Mt_HI_LO[0]) lo_d = Read_data_1;
                end
            end
            S_BUSY: begin
                Stall_HI_LO = 1'b1;
                w_d         = iter_next;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end else if (div0_q) begin
                        hi_d = rs_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = r_res;
                        lo_d = q_res;
                    end
                end
            end
            S_DONE: begin
                // A still-high HI_LO_write here is the retiring instruction.
                state_d = S_IDLE;
                if (Mt_HI_LO[1]) hi_d = Read_data_1;
                if (Mt_HI_LO[0]) lo_d = Read_data_1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            w_q      <= '0;
            b_q      <= '0;
            rs_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            w_q      <= w_d;
            b_q      <= b_d;
            rs_q     <= rs_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
        end
    end

    assign HI         = hi_q;
    assign LO         = lo_q;
    assign HI_LO_data = (HI_LO_move == 2'b10) ? hi_q :
                        (HI_LO_move == 2'b01) ? lo_q : 32'd0;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: cycle-timeline model of HI/LO and stall, with
// results from plain 64-bit arithmetic, plus directed literal checks.
module tb_hilo_muldiv_unit;
    localparam int ITER = 32;

    logic        clock, reset, HI_LO_write;
    logic [5:0]  Function_opcode;
    logic [1:0]  HI_LO_move, Mt_HI_LO;
    logic [31:0] Read_data_1, Read_data_2;
    logic        Stall_HI_LO;
    logic [31:0] HI_LO_data, HI, LO;

    hilo_muldiv_unit #(.ITER(ITER)) dut (
        .clock(clock), .reset(reset), .HI_LO_write(HI_LO_write),
        .Function_opcode(Function_opcode), .HI_LO_move(HI_LO_move),
        .Mt_HI_LO(Mt_HI_LO), .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
        .Stall_HI_LO(Stall_HI_LO), .HI_LO_data(HI_LO_data), .HI(HI), .LO(LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nchk = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_op(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb;
        int qa, qb;
        logic [63:0] r;
        case (op)
            6'b011000: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = 64'(sa * sb);
            end
            6'b011001: r = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else if (op == 6'b011011)
                    r = {a % b, a / b};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else begin
                    qa = $signed(a);
                    qb = $signed(b);
                    r  = {32'(qa % qb), 32'(qa / qb)};
                end
            end
        endcase
        return r;
    endfunction

    // Timeline model: m_left = busy cycles still to come, m_done = result cycle.
    int          m_left;
    bit          m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;

    always @(posedge clock) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_done <= 1'b1;
            end
        end else if (!m_done && HI_LO_write) begin
            m_left <= ITER;
            m_pend <= ref_op(Function_opcode, Read_data_1, Read_data_2);
        end else begin
            m_done <= 1'b0;
            if (Mt_HI_LO[1]) m_hi <= Read_data_1;
            if (Mt_HI_LO[0]) m_lo <= Read_data_1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            cmp("stall", {31'd0, Stall_HI_LO},
                {31'd0, (m_left > 0) || (!m_done && HI_LO_write)});
            cmp("hi", HI, m_hi);
            cmp("lo", LO, m_lo);
            cmp("hi_lo_data", HI_LO_data,
                (HI_LO_move == 2'b10) ? m_hi : (HI_LO_move == 2'b01) ? m_lo : 32'd0);
        end
    end

    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input logic [1:0] mt_acc, input logic [1:0] mt_done,
                         input logic [31:0] mt_val, output int n);
        HI_LO_write = 1'b1; Function_opcode = op;
        Read_data_1 = a; Read_data_2 = b;
        Mt_HI_LO = mt_acc; HI_LO_move = 2'b00;
        #1;
        n = 0;
        while (Stall_HI_LO && n < 100) begin
            n++;
            @(posedge clock); #1;
            if (!hold) HI_LO_write = 1'b0;
            Mt_HI_LO = 2'($urandom); HI_LO_move = 2'($urandom); Read_data_1 = $urandom;
            #1;
        end
        if (n >= 100) cmp("op_timeout", 32'(n), 32'(ITER + 1));
        Mt_HI_LO = mt_done; HI_LO_move = 2'b00;
        if (mt_done != 2'b00) Read_data_1 = mt_val;
        @(posedge clock); #1;
        HI_LO_write = 1'b0; Mt_HI_LO = 2'b00;
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ops [4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

    initial begin
        int n;
        reset = 1'b1; HI_LO_write = 1'b0; Function_opcode = '0;
        HI_LO_move = '0; Mt_HI_LO = '0; Read_data_1 = '0; Read_data_2 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0; chk_en = 1'b1;
        #1;
        cmp("reset_hi", HI, 32'd0);
        cmp("reset_lo", LO, 32'd0);
        cmp("reset_stall", {31'd0, Stall_HI_LO}, 32'd0);

        do_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00, 2'b00, 32'd0, n);
        cmp("multu_stall_len", 32'(n), 32'(ITER + 1));
        cmp("multu_hi", HI, 32'hFFFF_FFFE);
        cmp("multu_lo", LO, 32'h0000_0001);
        cmp("multu_no_restart", {31'd0, Stall_HI_LO}, 32'd0);

        do_op(6'b011000, 32'hFFFF_FFFD, 32'd7, 1'b0, 2'b10, 2'b00, 32'd0, n);
        cmp("mult_hi", HI, 32'hFFFF_FFFF);
        cmp("mult_lo", LO, 32'hFFFF_FFEB);
        HI_LO_move = 2'b10; #1;
        cmp("mfhi_data", HI_LO_data, 32'hFFFF_FFFF);
        cmp("mfhi_stall", {31'd0, Stall_HI_LO}, 32'd0);
        @(posedge clock); #1 HI_LO_move = 2'b00;

        do_op(6'b011010, 32'hFFFF_FFF9, 32'd2, 1'b1, 2'b00, 2'b00, 32'd0, n);
        cmp("div_lo", LO, 32'hFFFF_FFFD);
        cmp("div_hi", HI, 32'hFFFF_FFFF);
        do_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'b00, 2'b00, 32'd0, n);
        cmp("div_ovf_lo", LO, 32'h8000_0000);
        cmp("div_ovf_hi", HI, 32'd0);
        do_op(6'b011011, 32'h1234_5678, 32'd0, 1'b1, 2'b00, 2'b00, 32'd0, n);
        cmp("div0_lo", LO, 32'hFFFF_FFFF);
        cmp("div0_hi", HI, 32'h1234_5678);
        cmp("div0_stall_len", 32'(n), 32'(ITER + 1));

        Mt_HI_LO = 2'b10; Read_data_1 = 32'hA5A5_A5A5; #1;
        cmp("mthi_stall", {31'd0, Stall_HI_LO}, 32'd0);
        @(posedge clock); #1;
        cmp("mthi_hi", HI, 32'hA5A5_A5A5);
        Mt_HI_LO = 2'b01; Read_data_1 = 32'h5A5A_5A5A; #1;
        cmp("mtlo_stall", {31'd0, Stall_HI_LO}, 32'd0);
        @(posedge clock); #1;
        Mt_HI_LO = 2'b00;
        cmp("mtlo_lo", LO, 32'h5A5A_5A5A);
        cmp("mtlo_hi_kept", HI, 32'hA5A5_A5A5);

        do_op(6'b011001, 32'd3, 32'd5, 1'b1, 2'b00, 2'b01, 32'hCAFE_F00D, n);
        cmp("mtlo_done_lo", LO, 32'hCAFE_F00D);
        cmp("mtlo_done_hi", HI, 32'd0);

        // Reset while BUSY with counter at 10.
        Mt_HI_LO = 2'b10; Read_data_1 = 32'h1111_2222;
        @(posedge clock); #1;
        Mt_HI_LO = 2'b00;
        HI_LO_write = 1'b1; Function_opcode = 6'b011001;
        Read_data_1 = 32'hFFFF_FFFF; Read_data_2 = 32'd3;
        @(posedge clock); #1;
        HI_LO_write = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        cmp("busy_reset_hi", HI, 32'd0);
        cmp("busy_reset_lo", LO, 32'd0);
        cmp("busy_reset_stall", {31'd0, Stall_HI_LO}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            do_op(ops[$urandom_range(0, 3)], pick(), pick(), 1'($urandom), 2'($urandom),
                  2'($urandom), $urandom, n);
            cmp("rand_stall_len", 32'(n), 32'(ITER + 1));
            repeat ($urandom_range(0, 3)) begin
                Mt_HI_LO = 2'($urandom); HI_LO_move = 2'($urandom); Read_data_1 = $urandom;
                @(posedge clock); #1;
            end
            Mt_HI_LO = 2'b00; HI_LO_move = 2'b00;
        end

        @(posedge clock); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
